// File: rtl/pc_pkg.sv
// Shared definitions for the phase-correlation pipeline.
// Holds the image geometry, the float word width, the frame-word type and
// the streamer state encoding.
package pc_pkg;

    localparam int IMG_N   = 16;
    localparam int FLT_W   = 32;
    localparam int COORD_W = $clog2(IMG_N);

    // IEEE-754 single bit pattern, never interpreted by the streamer
    typedef logic [FLT_W-1:0] frame_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } strm_state_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (empties the FIFO)
//   wr_en_i, wr_data_i  push side
//   rd_en_i             pop the head word (ignored when empty)
//   rd_data_o           head word, valid whenever empty_o is low
//   empty_o, count_o    occupancy status
// Depth need not be a power of two; pointers wrap explicitly.
module stream_fifo
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_wr, do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_rd = rd_en_i && (count_q != '0);
    // A full FIFO may still take a write in the same cycle its head is popped.
    assign do_wr = wr_en_i && ((count_q != CNT_W'(DEPTH)) || do_rd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/img_frame_streamer.sv
// Streams one IMG_N x IMG_N frame from the image BRAM as a valid/ready word
// stream, in row-major or column-major order chosen per frame.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_i, col_major_i          frame request and order select
//   busy_o, done_o                frame in progress / one-cycle completion pulse
//   rom_en_o, rom_addr_o          BRAM read request
//   rom_data_i                    BRAM data, RD_LAT cycles after rom_en_o
//   m_valid_o, m_ready_i          output handshake
//   m_data_o, m_row_o, m_col_o    pixel word and its coordinates
//   m_last_line_o, m_last_o       end of row/column, end of frame
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing BRAM reads as credits allow
// DRAIN | all reads issued, emptying pipeline and FIFO
// DONE  | final beat accepted, done pulse
module img_frame_streamer
    import pc_pkg::*;
#(
    parameter int IMG_N  = pc_pkg::IMG_N,
    parameter int DATA_W = FLT_W,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     col_major_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     rom_en_o,
    output logic [ADDR_W-1:0]        rom_addr_o,
    input  logic [DATA_W-1:0]        rom_data_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [DATA_W-1:0]        m_data_o,
    output logic [$clog2(IMG_N)-1:0] m_row_o,
    output logic [$clog2(IMG_N)-1:0] m_col_o,
    output logic                     m_last_line_o,
    output logic                     m_last_o
);

    localparam int CW         = $clog2(IMG_N);
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int MW         = 2 * CW + 2;   // {row, col, last_line, last}
    localparam int FW         = DATA_W + MW;
    localparam logic [CW-1:0] CNT_MAX = CW'(IMG_N - 1);

    strm_state_t      state_q, state_d;
    logic             col_major_q, col_major_d;
    logic [CW-1:0]    outer_q, outer_d, inner_q, inner_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [RD_LAT-1:0] vld_q;
    logic [MW-1:0]    meta_q [RD_LAT];

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_wr;
    logic [FW-1:0]    fifo_rdata;
    logic [MW-1:0]    head_meta;
    logic [CW-1:0]    row, col;
    logic             last_line, last_pix, issue, pop;
    logic [CNT_W:0]   credit_used;

    assign row       = col_major_q ? inner_q : outer_q;
    assign col       = col_major_q ? outer_q : inner_q;
    assign last_line = (inner_q == CNT_MAX);
    assign last_pix  = last_line && (outer_q == CNT_MAX);

    assign pop = m_valid_o && m_ready_i;
    // Slot freed by this cycle's pop is reusable now, so back-to-back issue
    // is sustained with only RD_LAT+2 entries of storage.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count} - (CNT_W+1)'(pop);
    assign issue       = (state_q == RUN) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign fifo_wr     = vld_q[RD_LAT-1];

    always_comb begin
        state_d     = state_q;
        col_major_d = col_major_q;
        outer_d     = outer_q;
        inner_d     = inner_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = RUN;
                    col_major_d = col_major_i;
                    outer_d     = '0;
                    inner_d     = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    inner_d = last_line ? '0 : inner_q + 1'b1;
                    if (last_line) outer_d = (outer_q == CNT_MAX) ? '0 : outer_q + 1'b1;
                    if (last_pix) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last_o) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(fifo_wr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            col_major_q <= 1'b0;
            outer_q     <= '0;
            inner_q     <= '0;
            inflight_q  <= '0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            col_major_q <= col_major_d;
            outer_q     <= outer_d;
            inner_q     <= inner_d;
            inflight_q  <= inflight_d;
            vld_q       <= RD_LAT'({vld_q, issue});
        end
    end

    // Metadata needs no reset: it is only consumed where vld_q marks it.
    always_ff @(posedge clk_i) begin
        meta_q[0] <= {row, col, last_line, last_pix};
        for (int i = 1; i < RD_LAT; i++) meta_q[i] <= meta_q[i-1];
    end

    stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (fifo_wr),
        .wr_data_i ({rom_data_i, meta_q[RD_LAT-1]}),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign head_meta = fifo_rdata[MW-1:0];

    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign rom_en_o      = issue;
    assign rom_addr_o    = ADDR_W'(row) * ADDR_W'(IMG_N) + ADDR_W'(col);
    assign m_valid_o     = !fifo_empty;
    // Head fields are forced to zero while empty so stale storage never shows.
    assign m_data_o      = m_valid_o ? fifo_rdata[FW-1:MW] : '0;
    assign m_row_o       = m_valid_o ? head_meta[MW-1 -: CW] : '0;
    assign m_col_o       = m_valid_o ? head_meta[2 +: CW] : '0;
    assign m_last_line_o = m_valid_o && head_meta[1];
    assign m_last_o      = m_valid_o && head_meta[0];

endmodule

// File: tb/tb_img_frame_streamer.sv
module tb_img_frame_streamer;

    localparam int N     = 16;
    localparam int FRAME = N * N;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  r;
        logic [3:0]  c;
        logic        ll;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, col_major, m_ready;
    logic busy [2], done [2], rom_en [2], m_valid [2], m_last_line [2], m_last [2];
    logic [7:0]  rom_addr [2];
    logic [31:0] m_data [2];
    logic [3:0]  m_row [2], m_col [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t qs [2][$];
    int    ts [2][$];
    int done_cnt [2]  = '{0, 0};
    int done_cyc [2]  = '{-1, -1};
    int first_en [2]  = '{-1, -1};
    int max_addr [2]  = '{-1, -1};
    int busy_fall [2] = '{-1, -1};
    int outstanding [2] = '{0, 0};

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT   = g + 1;
        localparam int DEPTH = LAT + 2;
        logic [31:0] pipe0, pipe1, rd;
        logic        prev_stall, prev_busy;
        logic [31:0] prev_data;

        img_frame_streamer #(
            .IMG_N  (N),
            .DATA_W (32),
            .ADDR_W (8),
            .RD_LAT (LAT)
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .start_i       (start),
            .col_major_i   (col_major),
            .busy_o        (busy[g]),
            .done_o        (done[g]),
            .rom_en_o      (rom_en[g]),
            .rom_addr_o    (rom_addr[g]),
            .rom_data_i    (rd),
            .m_valid_o     (m_valid[g]),
            .m_ready_i     (m_ready),
            .m_data_o      (m_data[g]),
            .m_row_o       (m_row[g]),
            .m_col_o       (m_col[g]),
            .m_last_line_o (m_last_line[g]),
            .m_last_o      (m_last[g])
        );

        // BRAM model: word at address a is {24'h0, a}
        always @(posedge clk) begin
            if (rom_en[g]) pipe0 <= {24'h0, rom_addr[g]};
            pipe1 <= pipe0;
        end
        assign rd = (LAT == 1) ? pipe0 : pipe1;

        always @(negedge clk) begin
            if (rst) begin
                outstanding[g] = 0;
                prev_stall = 1'b0;
                prev_busy  = 1'b0;
            end else begin
                if (rom_en[g]) begin
                    if (first_en[g] < 0) first_en[g] = cyc;
                    if (int'(rom_addr[g]) > max_addr[g]) max_addr[g] = int'(rom_addr[g]);
                end
                outstanding[g] = outstanding[g] + (rom_en[g] ? 1 : 0) - ((m_valid[g] && m_ready) ? 1 : 0);
                n_checks++;
                if (outstanding[g] > DEPTH || outstanding[g] < 0) begin
                    n_fail++;
                    $display("FAIL credit[%0d] at cycle %0d: outstanding=%0d, required 0..%0d", g, cyc, outstanding[g], DEPTH);
                end
                if (prev_stall) begin
                    n_checks++;
                    if (m_valid[g] !== 1'b1 || m_data[g] !== prev_data) begin
                        n_fail++;
                        $display("FAIL hold[%0d] at cycle %0d: valid=%b data=%h, required valid=1 data=%h", g, cyc, m_valid[g], m_data[g], prev_data);
                    end
                end
                prev_stall = m_valid[g] && !m_ready;
                prev_data  = m_data[g];
                if (m_valid[g] && m_ready) begin
                    qs[g].push_back('{m_data[g], m_row[g], m_col[g], m_last_line[g], m_last[g]});
                    ts[g].push_back(cyc);
                end
                if (done[g]) begin
                    done_cnt[g]++;
                    done_cyc[g] = cyc;
                end
                if (prev_busy && !busy[g]) busy_fall[g] = cyc;
                prev_busy = busy[g];
            end
        end
    end

    // Reference: beat k of a frame in the requested order
    function automatic beat_t exp_beat(int k, bit colm);
        int a;
        beat_t b;
        a    = colm ? (k % N) * N + k / N : k;
        b.d  = 32'(a);
        b.r  = 4'(a / N);
        b.c  = 4'(a % N);
        b.ll = (k % N == N - 1);
        b.l  = (k == FRAME - 1);
        return b;
    endfunction

    task automatic clear_obs();
        for (int i = 0; i < 2; i++) begin
            qs[i].delete();
            ts[i].delete();
            done_cnt[i]  = 0;
            done_cyc[i]  = -1;
            first_en[i]  = -1;
            max_addr[i]  = -1;
            busy_fall[i] = -1;
        end
    endtask

    task automatic pulse_start(input bit colm, output int t0);
        @(posedge clk); #1;
        start = 1'b1;
        col_major = colm;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_frames(input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            if (done_cnt[0] > 0 && done_cnt[1] > 0 && !busy[0] && !busy[1]) begin
                ok = 1'b1;
                break;
            end
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({busy[i], done[i], rom_en[i], m_valid[i], m_last[i], m_last_line[i], rom_addr[i], m_row[i], m_col[i]} !== 22'h0) begin
                n_fail++;
                $display("FAIL reset[%0d]: busy=%b done=%b en=%b valid=%b last=%b ll=%b addr=%h row=%h col=%h, required all 0",
                         i, busy[i], done[i], rom_en[i], m_valid[i], m_last[i], m_last_line[i], rom_addr[i], m_row[i], m_col[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_row_major();
        int t0;
        bit ok;
        clear_obs();
        pulse_start(1'b0, t0);
        wait_frames(1000, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL row_timeout: got busy=%b/%b, required idle", busy[0], busy[1]); end
        for (int i = 0; i < 2; i++) begin
            int lat;
            lat = i + 1;
            n_checks++;
            if (qs[i].size() != FRAME) begin n_fail++; $display("FAIL row_count[%0d]: got %0d, required %0d", i, qs[i].size(), FRAME); end
            for (int k = 0; k < qs[i].size(); k++) begin
                n_checks++;
                if (qs[i][k] !== exp_beat(k, 1'b0) || ts[i][k] - t0 != 2 + lat + k) begin
                    n_fail++;
                    $display("FAIL row_beat[%0d] %0d: got %h at cycle %0d, required %h at cycle %0d", i, k, qs[i][k], ts[i][k] - t0, exp_beat(k, 1'b0), 2 + lat + k);
                end
            end
            n_checks++;
            if (first_en[i] - t0 != 1) begin n_fail++; $display("FAIL first_en[%0d]: got cycle %0d, required 1", i, first_en[i] - t0); end
            n_checks++;
            if (done_cnt[i] != 1 || done_cyc[i] - t0 != 258 + lat) begin
                n_fail++;
                $display("FAIL row_done[%0d]: got %0d pulses at cycle %0d, required 1 at cycle %0d", i, done_cnt[i], done_cyc[i] - t0, 258 + lat);
            end
            n_checks++;
            if (busy_fall[i] - t0 != 259 + lat) begin n_fail++; $display("FAIL busy_fall[%0d]: got cycle %0d, required %0d", i, busy_fall[i] - t0, 259 + lat); end
        end
    endtask

    task automatic test_col_major();
        int t0;
        bit ok;
        clear_obs();
        pulse_start(1'b1, t0);
        wait_frames(1000, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL col_timeout: got busy=%b/%b, required idle", busy[0], busy[1]); end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (qs[i].size() != FRAME || done_cnt[i] != 1) begin
                n_fail++;
                $display("FAIL col_count[%0d]: got %0d beats %0d done, required %0d beats 1 done", i, qs[i].size(), done_cnt[i], FRAME);
            end
            for (int k = 0; k < qs[i].size(); k++) begin
                n_checks++;
                if (qs[i][k] !== exp_beat(k, 1'b1)) begin
                    n_fail++;
                    $display("FAIL col_beat[%0d] %0d: got %h, required %h", i, k, qs[i][k], exp_beat(k, 1'b1));
                end
            end
        end
    endtask

    task automatic test_random_ready();
        int t0;
        bit ok;
        for (int f = 0; f < 2; f++) begin
            bit colm;
            colm = (f == 1);
            clear_obs();
            pulse_start(colm, t0);
            wait_frames(3000, 1'b1, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL rand_timeout frame %0d: got busy=%b/%b, required idle", f, busy[0], busy[1]); end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (qs[i].size() != FRAME || done_cnt[i] != 1) begin
                    n_fail++;
                    $display("FAIL rand_count[%0d] frame %0d: got %0d beats %0d done, required %0d beats 1 done", i, f, qs[i].size(), done_cnt[i], FRAME);
                end
                for (int k = 0; k < qs[i].size(); k++) begin
                    n_checks++;
                    if (qs[i][k] !== exp_beat(k, colm)) begin
                        n_fail++;
                        $display("FAIL rand_beat[%0d] frame %0d beat %0d: got %h, required %h", i, f, k, qs[i][k], exp_beat(k, colm));
                    end
                end
            end
        end
    endtask

    task automatic test_busy_start();
        int t0, t1;
        bit ok;
        clear_obs();
        pulse_start(1'b0, t0);
        for (int c = 0; c < 200 && qs[0].size() < 50; c++) begin
            @(posedge clk); #1;
        end
        pulse_start(1'b1, t1);
        wait_frames(1000, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL busy_timeout: got busy=%b/%b, required idle", busy[0], busy[1]); end
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (done_cnt[i] != 1 || busy[i] !== 1'b0 || qs[i].size() != FRAME) begin
                n_fail++;
                $display("FAIL busy_start[%0d]: got done=%0d busy=%b beats=%0d, required done=1 busy=0 beats=%0d", i, done_cnt[i], busy[i], qs[i].size(), FRAME);
            end
            for (int k = 0; k < qs[i].size(); k++) begin
                n_checks++;
                if (qs[i][k] !== exp_beat(k, 1'b0)) begin
                    n_fail++;
                    $display("FAIL busy_beat[%0d] %0d: got %h, required %h", i, k, qs[i][k], exp_beat(k, 1'b0));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        bit ok;
        clear_obs();
        pulse_start(1'b0, t0);
        for (int c = 0; c < 300 && qs[0].size() < 100; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({m_valid[i], rom_en[i], busy[i], done[i], m_last[i], rom_addr[i]} !== 13'h0) begin
                n_fail++;
                $display("FAIL rst_mid[%0d]: valid=%b en=%b busy=%b done=%b last=%b addr=%h, required all 0", i, m_valid[i], rom_en[i], busy[i], done[i], m_last[i], rom_addr[i]);
            end
        end
        clear_obs();
        repeat (2) @(posedge clk);
        pulse_start(1'b0, t0);
        wait_frames(1000, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rst_timeout: got busy=%b/%b, required idle", busy[0], busy[1]); end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (qs[i].size() != FRAME || done_cnt[i] != 1) begin
                n_fail++;
                $display("FAIL rst_count[%0d]: got %0d beats %0d done, required %0d beats 1 done", i, qs[i].size(), done_cnt[i], FRAME);
            end
            for (int k = 0; k < qs[i].size(); k++) begin
                n_checks++;
                if (qs[i][k] !== exp_beat(k, 1'b0)) begin
                    n_fail++;
                    $display("FAIL rst_beat[%0d] %0d: got %h, required %h", i, k, qs[i][k], exp_beat(k, 1'b0));
                end
            end
        end
    endtask

    task automatic test_stall();
        int t0;
        int a [2];
        bit ok;
        clear_obs();
        pulse_start(1'b0, t0);
        for (int c = 0; c < 100 && qs[0].size() < 10; c++) begin
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) a[i] = qs[i].size();
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (m_valid[i] !== 1'b1 || m_data[i] !== 32'(a[i])) begin
                    n_fail++;
                    $display("FAIL stall_head[%0d] cycle %0d: got valid=%b data=%h, required valid=1 data=%h", i, c, m_valid[i], m_data[i], 32'(a[i]));
                end
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rom_en[i] !== 1'b0 || max_addr[i] != a[i] + (i + 3) - 1) begin
                n_fail++;
                $display("FAIL stall_issue[%0d]: got en=%b last_addr=%0d, required en=0 last_addr=%0d", i, rom_en[i], max_addr[i], a[i] + (i + 3) - 1);
            end
        end
        m_ready = 1'b1;
        wait_frames(1000, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stall_timeout: got busy=%b/%b, required idle", busy[0], busy[1]); end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (qs[i].size() != FRAME || done_cnt[i] != 1) begin
                n_fail++;
                $display("FAIL stall_count[%0d]: got %0d beats %0d done, required %0d beats 1 done", i, qs[i].size(), done_cnt[i], FRAME);
            end
            for (int k = 0; k < qs[i].size(); k++) begin
                n_checks++;
                if (qs[i][k] !== exp_beat(k, 1'b0)) begin
                    n_fail++;
                    $display("FAIL stall_beat[%0d] %0d: got %h, required %h", i, k, qs[i][k], exp_beat(k, 1'b0));
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        col_major = 1'b0;
        m_ready   = 1'b1;
        test_reset();
        test_row_major();
        test_col_major();
        test_random_ready();
        test_busy_start();
        test_reset_mid();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
